// File: rtl/axis_phase_burst_gate.sv
// axis_phase_burst_gate
//
// Gates a free-running phase stream into bursts of an exact whole number of
// periods. A trigger arms the gate. The burst then starts on the next phase
// wrap and covers cfg_cycles complete periods. Outside a burst, input samples
// are still accepted and dropped. This keeps the upstream phase generator
// running and phase-continuous.
//
// Ports
//   aclk, aresetn          clock, asynchronous active-low reset
//   trg                    start request (honoured only when idle)
//   cfg_cycles             periods per burst, latched on an accepted trigger
//   s_axis_*               phase input; tdata[PHASE_WIDTH-1:0] is the phase
//   m_axis_*               forwarded phase, unmodified, one register stage
//   sts_busy               high while armed or active
//   sts_count              periods completed in the current burst
//   sts_done               one-cycle pulse when a burst completes
//
// Handshake: a beat transfers on a rising edge where tvalid & tready are both
// high. tdata is held stable while tvalid is high and tready is low. The input
// is ready whenever the output register is empty or being drained this cycle.
module axis_phase_burst_gate #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int PHASE_WIDTH      = 30,
  parameter int CNTR_WIDTH       = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        trg,
  input  logic [CNTR_WIDTH-1:0]       cfg_cycles,
  output logic                        s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        sts_busy,
  output logic [CNTR_WIDTH-1:0]       sts_count,
  output logic                        sts_done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t                      state, state_nxt;
  logic [PHASE_WIDTH-1:0]      prev;
  logic                        prev_vld;
  logic [PHASE_WIDTH-1:0]      phase;
  logic [CNTR_WIDTH-1:0]       cycles, cycles_nxt;
  logic [CNTR_WIDTH-1:0]       count, count_nxt, count_inc;
  logic                        done_nxt;
  logic                        fwd;
  logic                        acc;
  logic                        wrap;
  logic [AXIS_TDATA_WIDTH-1:0] tdata_q;
  logic                        tvalid_q;
  logic                        done_q;

  assign s_axis_tready = ~tvalid_q | m_axis_tready;
  assign acc           = s_axis_tvalid & s_axis_tready;
  assign phase         = s_axis_tdata[PHASE_WIDTH-1:0];
  // A wrap is a decrease in phase. prev_vld masks the first sample after
  // reset. A zero increment gives phase == prev, which is never a wrap.
  assign wrap          = acc & prev_vld & (phase < prev);
  assign count_inc     = count + CNTR_WIDTH'(1);

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign sts_busy      = (state != ST_IDLE);
  assign sts_count     = count;
  assign sts_done      = done_q;

  always_comb begin
    state_nxt  = state;
    cycles_nxt = cycles;
    count_nxt  = count;
    done_nxt   = 1'b0;
    fwd        = 1'b0;
    case (state)
      ST_IDLE: begin
        // Samples accepted in this cycle are evaluated here and dropped.
        if (trg && (cfg_cycles != '0)) begin
          cycles_nxt = cfg_cycles;
          count_nxt  = '0;
          state_nxt  = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (wrap) begin
          fwd       = 1'b1;
          state_nxt = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (wrap) begin
          count_nxt = count_inc;
          if (count_inc == cycles) begin
            // The closing wrap belongs to the next period, so it is dropped.
            done_nxt  = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            fwd = 1'b1;
          end
        end else if (acc) begin
          fwd = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= ST_IDLE;
      cycles   <= '0;
      count    <= '0;
      done_q   <= 1'b0;
      prev     <= '0;
      prev_vld <= 1'b0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cycles <= cycles_nxt;
      count  <= count_nxt;
      done_q <= done_nxt;
      // Wrap tracking follows every accepted sample, in every state.
      if (acc) begin
        prev     <= phase;
        prev_vld <= 1'b1;
      end
      // fwd implies acc, and acc implies the register is free or draining.
      if (fwd) begin
        tdata_q  <= s_axis_tdata;
        tvalid_q <= 1'b1;
      end else if (m_axis_tready) begin
        tvalid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_phase_burst_gate.sv
// Bench for axis_phase_burst_gate. A phase generator feeds the gate.
// The reference model treats a burst as a window of wrap counts. After a
// trigger, the gate forwards a sample while the number of wraps seen,
// including the one in that sample, lies between 1 and cycles. The wrap that
// brings the count to cycles+1 ends the burst.
module tb_axis_phase_burst_gate;

  localparam int DW = 32;
  localparam int PW = 30;
  localparam int CW = 16;

  logic          aclk;
  logic          aresetn;
  logic          trg;
  logic [CW-1:0] cfg_cycles;
  logic          s_axis_tready;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          m_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          sts_busy;
  logic [CW-1:0] sts_count;
  logic          sts_done;

  axis_phase_burst_gate #(
    .AXIS_TDATA_WIDTH(DW),
    .PHASE_WIDTH(PW),
    .CNTR_WIDTH(CW)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .trg(trg),
    .cfg_cycles(cfg_cycles),
    .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .sts_busy(sts_busy),
    .sts_count(sts_count),
    .sts_done(sts_done)
  );

  // ---------------- clock / reset ----------------
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- phase generator ----------------
  logic [PW-1:0]    gen_phase = '0;
  logic [DW-PW-1:0] gen_hi    = '0;
  logic [PW-1:0]    inc       = PW'(1) << 28;
  logic             adv       = 1'b0;

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  logic [PW-1:0] m_prev     = '0;
  logic          m_prev_vld = 1'b0;
  logic          m_busy     = 1'b0;
  logic          m_done     = 1'b0;
  int            m_wraps    = 0;
  int            m_cyc      = 0;
  logic          held_v     = 1'b0;
  logic [DW-1:0] held_d     = '0;
  int            out_cnt    = 0;
  int            done_cnt   = 0;

  function automatic logic [CW-1:0] m_count();
    return (m_wraps == 0) ? CW'(0) : CW'(m_wraps - 1);
  endfunction

  // One clock cycle. Inputs are driven at negedge and everything is checked
  // 1ns later. The model then predicts the effect of the coming posedge.
  task automatic step(input logic t, input logic [CW-1:0] c, input logic v, input logic r);
    logic          m_rdy;
    logic          acc;
    logic          wrp;
    logic          busy0;
    logic [PW-1:0] ph;
    @(negedge aclk);
    if (adv) begin
      gen_phase = gen_phase + inc;
      gen_hi    = (DW-PW)'($urandom_range(0, 3));
      adv       = 1'b0;
    end
    trg           = t;
    cfg_cycles    = c;
    s_axis_tvalid = v;
    m_axis_tready = r;
    s_axis_tdata  = {gen_hi, gen_phase};
    #1;
    chk("busy", sts_busy, m_busy);
    chk("count", sts_count, m_count());
    chk("done", sts_done, m_done);
    chk("vld", m_axis_tvalid, exp_q.size() != 0);
    m_rdy = (exp_q.size() == 0) || r;
    chk("s_rdy", s_axis_tready, m_rdy);
    if (held_v) chk("hold", m_axis_tdata, held_d);
    held_v = m_axis_tvalid && !r;
    held_d = m_axis_tdata;
    if (m_axis_tvalid && r) begin
      if (exp_q.size() == 0) chk("extra", 1, 0);
      else begin
        chk("data", m_axis_tdata, exp_q.pop_front());
        out_cnt++;
      end
    end
    if (sts_done) done_cnt++;
    // model of the coming edge
    acc    = v && m_rdy;
    busy0  = m_busy;
    m_done = 1'b0;
    if (acc) begin
      ph         = gen_phase;
      wrp        = m_prev_vld && (ph < m_prev);
      m_prev     = ph;
      m_prev_vld = 1'b1;
      adv        = 1'b1;
      if (m_busy) begin
        if (wrp) m_wraps++;
        if (m_wraps >= 1 && m_wraps <= m_cyc) exp_q.push_back({gen_hi, gen_phase});
        else if (m_wraps == m_cyc + 1) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end
    end
    if (!busy0 && t && c != 0) begin
      m_busy  = 1'b1;
      m_wraps = 0;
      m_cyc   = int'(c);
    end
  endtask

  task automatic do_reset();
    @(negedge aclk);
    trg           = 1'b0;
    s_axis_tvalid = 1'b0;
    #3;
    aresetn = 1'b0;
    #1;
    chk("rst_vld", m_axis_tvalid, 0);
    chk("rst_data", m_axis_tdata, 0);
    chk("rst_busy", sts_busy, 0);
    chk("rst_count", sts_count, 0);
    chk("rst_done", sts_done, 0);
    chk("rst_s_rdy", s_axis_tready, 1);
    exp_q.delete();
    m_prev     = '0;
    m_prev_vld = 1'b0;
    m_busy     = 1'b0;
    m_done     = 1'b0;
    m_wraps    = 0;
    held_v     = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  // mode 0: tready=1, mode 1: tready pattern 1,0,0, mode 2: random
  task automatic run_idle(input logic [CW-1:0] c, input int mode);
    int n;
    n = 0;
    while ((m_busy || exp_q.size() != 0) && n < 600) begin
      step(1'b0, c, 1'b1, (mode == 0) ? 1'b1 : (mode == 1) ? (n % 3 == 0) : 1'($urandom_range(0, 1)));
      n++;
    end
    if (n >= 600) chk("timeout", 1, 0);
    step(1'b0, c, 1'b1, 1'b1);
    step(1'b0, c, 1'b1, 1'b1);
  endtask

  task automatic run_until_out(input int target, input logic [CW-1:0] c);
    int n;
    n = 0;
    while (out_cnt < target && n < 200) begin
      step(1'b0, c, 1'b1, 1'b1);
      n++;
    end
    if (n >= 200) chk("timeout_out", 1, 0);
  endtask

  task automatic clear_counts();
    out_cnt  = 0;
    done_cnt = 0;
  endtask

  initial begin
    aresetn       = 1'b0;
    trg           = 1'b0;
    cfg_cycles    = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b1;
    repeat (3) @(negedge aclk);
    chk("init_vld", m_axis_tvalid, 0);
    chk("init_busy", sts_busy, 0);
    chk("init_count", sts_count, 0);
    chk("init_done", sts_done, 0);
    chk("init_s_rdy", s_axis_tready, 1);
    aresetn = 1'b1;

    // period-4 stream, two periods
    inc = PW'(1) << 28;
    clear_counts();
    step(1'b1, 16'd2, 1'b1, 1'b1);
    run_idle(16'd2, 0);
    chk("c2_out", out_cnt, 8);
    chk("c2_done", done_cnt, 1);
    chk("c2_count", sts_count, 2);

    // zero cycles: trigger ignored
    clear_counts();
    step(1'b1, 16'd0, 1'b1, 1'b1);
    repeat (12) step(1'b0, 16'd0, 1'b1, 1'b1);
    chk("c0_out", out_cnt, 0);
    chk("c0_done", done_cnt, 0);

    // backpressure 1,0,0
    clear_counts();
    step(1'b1, 16'd1, 1'b1, 1'b1);
    run_idle(16'd1, 1);
    chk("bp_out", out_cnt, 4);
    chk("bp_done", done_cnt, 1);

    // retrigger and cfg change mid-burst
    clear_counts();
    step(1'b1, 16'd3, 1'b1, 1'b1);
    run_until_out(3, 16'd3);
    step(1'b1, 16'd5, 1'b1, 1'b1);
    run_idle(16'd5, 0);
    chk("rt_out", out_cnt, 12);
    chk("rt_count", sts_count, 3);
    chk("rt_done", done_cnt, 1);

    // reset mid-burst
    clear_counts();
    step(1'b1, 16'd3, 1'b1, 1'b1);
    run_until_out(2, 16'd3);
    do_reset();
    clear_counts();
    step(1'b1, 16'd1, 1'b1, 1'b1);
    run_idle(16'd1, 0);
    chk("rs_out", out_cnt, 4);
    chk("rs_done", done_cnt, 1);

    // non-integer period 8/3
    inc = PW'(3) << 27;
    clear_counts();
    step(1'b1, 16'd3, 1'b1, 1'b1);
    run_idle(16'd3, 0);
    chk("ni_out", out_cnt, 8);
    chk("ni_count", sts_count, 3);

    // zero increment never wraps: stays armed
    inc = '0;
    clear_counts();
    step(1'b1, 16'd1, 1'b1, 1'b1);
    repeat (15) step(1'b0, 16'd1, 1'b1, 1'b1);
    chk("z_busy", sts_busy, 1);
    chk("z_out", out_cnt, 0);
    do_reset();

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      if (i % 150 == 0) inc = PW'($urandom_range(1 << 25, 1 << 29));
      step(1'($urandom_range(0, 7) == 0), CW'($urandom_range(0, 3)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
    end
    run_idle(16'd0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
